pc_alu: RTL and testbench
=========================

# pc_alu

Program-counter arithmetic and PC register for the 16-bit accumulator processor. Computes the sequential next PC (current PC + 2, one 16-bit instruction word) and the PC-relative branch target, and holds the architectural PC in a register. The next-PC source is selected by the control unit. Sits between the control unit, the instruction memory address port and the immediate field of the instruction register.

## Interface
Parameters:
- WIDTH, 16, PC / address width in bits.
- IMMW, 12, width of the signed branch offset field, in instruction words.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- PCIN  in  WIDTH  PC operand for the combinational adders.
- PCOUT  out  WIDTH  PCIN + 2, combinational.
- CARRY  out  1  carry-out of PCIN + 2, combinational.
- IMM  in  IMMW  signed branch offset, in words.
- BROUT  out  WIDTH  branch target, combinational.
- JADDR  in  WIDTH  absolute jump address.
- PCSRC  in  2  next-PC select: 00 increment, 01 branch, 10 jump, 11 hold.
- PCWRITE  in  1  PC register write enable.
- PC  out  WIDTH  registered architectural PC.

## Operation
- PCOUT = (PCIN + 2) mod 2^WIDTH.
  - Pure combinational; no dependence on CLK, RST or any other input.
  - Odd PCIN values pass through unaligned: PCIN 5 -> PCOUT 7.
- CARRY = 1 exactly when PCIN >= 2^WIDTH - 2 (16'hFFFE or 16'hFFFF).
- BROUT = (PCOUT + (sign_extend(IMM) << 1)) mod 2^WIDTH.
  - The offset is relative to the incremented PC.
  - Wraps silently in both directions.
- Next-PC mux, with PCIN internally tied to PC for the register path:
  - 00 -> PC + 2.
  - 01 -> PC + 2 + (sext(IMM) << 1).
  - 10 -> {JADDR[WIDTH-1:1], 1'b0}; bit 0 is forced to 0 for alignment.
  - 11 -> PC (hold).
- Separate adder instances serve the external PCIN path and the internal register path. The external outputs always reflect PCIN, not PC.
- PCWRITE = 0: PC holds regardless of PCSRC.

## Timing
- PCOUT, CARRY and BROUT are combinational, zero-cycle latency. They are valid within the same cycle as PCIN/IMM changes.
- PC updates on the rising CLK edge when PCWRITE = 1. Latency is one cycle from the select inputs to PC.
- RST asserted: PC = RESET_PC immediately, without waiting for a clock edge. It stays there while RST is high.
- RST deasserted: the first update is on the next rising edge with PCWRITE = 1.
- RST has priority over PCWRITE at every edge.
- RST does not affect PCOUT, CARRY or BROUT.
- PC wrap: 16'hFFFE with PCSRC = 00 loads 16'h0000. No trap, no stall.

## Structure
- Shared package pc_pkg:
  - PCSRC encodings PCSRC_INC, PCSRC_BR, PCSRC_JMP, PCSRC_HOLD.
  - Constant INSTR_BYTES = 2.
  - Default WIDTH / IMMW.
- One natural sub-module, pc_adder: WIDTH-bit adder with operand A, operand B and carry-out.
  - Instantiate it for each +2 path and each branch-target add.
- The top level holds only the muxes and the PC register.

## Test plan
- PCIN = 0, 5, 10, 15, 20, each held 100 ns with no clock -> PCOUT = 2, 7, 12, 17, 22, CARRY = 0.
- PCIN = 16'hFFFE -> PCOUT = 16'h0000, CARRY = 1. PCIN = 16'hFFFF -> PCOUT = 16'h0001, CARRY = 1.
- PCIN = 16'h0100 with IMM = 12'h004 -> BROUT = 16'h010A. With IMM = 12'hFFF (-1) -> BROUT = 16'h0100.
- RST pulse mid-cycle with PC = 16'h1234 -> PC = 16'h0000 before the next edge. Then PCWRITE = 1, PCSRC = 00 over 3 edges -> PC = 2, 4, 6.
- PC = 16'h0010:
  - PCSRC = 10, JADDR = 16'h2001 -> PC = 16'h2000.
  - Then PCSRC = 11 -> PC holds 16'h2000.
  - Then PCWRITE = 0, PCSRC = 00 -> PC holds 16'h2000.
- PC = 16'hFFFE, PCSRC = 00, PCWRITE = 1 -> PC = 16'h0000 after one edge.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC select encodings and PC arithmetic constants
package pc_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_IMMW    = 12;
  localparam int INSTR_BYTES = 2;

  typedef enum logic [1:0] {
    PCSRC_INC  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_JMP  = 2'b10,
    PCSRC_HOLD = 2'b11
  } pcsrc_e;

endpackage

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - WIDTH-bit unsigned adder with carry-out
module pc_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/pc_alu.sv
// rtl/pc_alu.sv - PC increment/branch-target arithmetic and architectural PC register
module pc_alu
  import pc_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               IMMW     = DEF_IMMW,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PCIN,
  output logic [WIDTH-1:0] PCOUT,
  output logic             CARRY,
  input  logic [IMMW-1:0]  IMM,
  output logic [WIDTH-1:0] BROUT,
  input  logic [WIDTH-1:0] JADDR,
  input  logic [1:0]       PCSRC,
  input  logic             PCWRITE,
  output logic [WIDTH-1:0] PC
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

  // Word offset scaled to bytes: sign-extend, then shift left by one.
  logic [WIDTH-1:0] offset;
  assign offset = {{(WIDTH-IMMW-1){IMM[IMMW-1]}}, IMM, 1'b0};

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_br;
  logic [WIDTH-1:0] pc_next;
  logic             ext_br_carry_unused;
  logic             int_inc_carry_unused;
  logic             int_br_carry_unused;

  // External path: driven purely by PCIN, independent of the register.
  pc_adder #(.WIDTH(WIDTH)) u_ext_inc (
    .a(PCIN), .b(STEP), .sum(PCOUT), .carry(CARRY)
  );

  pc_adder #(.WIDTH(WIDTH)) u_ext_br (
    .a(PCOUT), .b(offset), .sum(BROUT), .carry(ext_br_carry_unused)
  );

  // Register path: same arithmetic applied to the current PC.
  pc_adder #(.WIDTH(WIDTH)) u_int_inc (
    .a(PC), .b(STEP), .sum(pc_inc), .carry(int_inc_carry_unused)
  );

  pc_adder #(.WIDTH(WIDTH)) u_int_br (
    .a(pc_inc), .b(offset), .sum(pc_br), .carry(int_br_carry_unused)
  );

  always_comb begin
    pc_next = PC;
    case (pcsrc_e'(PCSRC))
      PCSRC_INC:  pc_next = pc_inc;
      PCSRC_BR:   pc_next = pc_br;
      PCSRC_JMP:  pc_next = {JADDR[WIDTH-1:1], 1'b0};
      PCSRC_HOLD: pc_next = PC;
      default:    pc_next = PC;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC <= RESET_PC;
    end else if (PCWRITE) begin
      PC <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_alu.sv
// tb/tb_pc_alu.sv - self-checking bench for pc_alu with a behavioural PC model
module tb_pc_alu;

  logic        CLK;
  logic        RST;
  logic [15:0] PCIN;
  logic [15:0] PCOUT;
  logic        CARRY;
  logic [11:0] IMM;
  logic [15:0] BROUT;
  logic [15:0] JADDR;
  logic [1:0]  PCSRC;
  logic        PCWRITE;
  logic [15:0] PC;

  int  n_total = 0;
  int  n_pass  = 0;
  bit  clk_run = 0;
  bit  check_en = 0;
  logic [15:0] m_pc = 16'h0000;

  pc_alu #(.WIDTH(16), .IMMW(12), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .PCIN(PCIN), .PCOUT(PCOUT), .CARRY(CARRY),
    .IMM(IMM), .BROUT(BROUT), .JADDR(JADDR), .PCSRC(PCSRC),
    .PCWRITE(PCWRITE), .PC(PC)
  );

  initial begin
    CLK = 0;
    forever #5 if (clk_run) CLK = ~CLK;
  end

  function automatic logic [15:0] f_inc(input logic [15:0] a);
    int t;
    t = int'(a) + 2;
    return t[15:0];
  endfunction

  function automatic logic f_carry(input logic [15:0] a);
    return (int'(a) + 2) >= 65536;
  endfunction

  function automatic logic [15:0] f_br(input logic [15:0] a, input logic [11:0] imm);
    int t;
    t = int'(a) + 2 + 2 * int'($signed(imm));
    return t[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference PC: architectural rules applied directly.
  always @(posedge CLK or posedge RST) begin
    if (RST) m_pc = 16'h0000;
    else if (PCWRITE) begin
      case (PCSRC)
        2'b00: m_pc = f_inc(m_pc);
        2'b01: m_pc = f_br(m_pc, IMM);
        2'b10: m_pc = {JADDR[15:1], 1'b0};
        default: m_pc = m_pc;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      chk("model_pc", PC, m_pc);
      chk("model_pcout", PCOUT, f_inc(PCIN));
      chk("model_carry", CARRY, f_carry(PCIN));
      chk("model_brout", BROUT, f_br(PCIN, IMM));
    end
  end

  task automatic cyc(input logic w, input logic [1:0] s, input logic [15:0] j,
                     input logic [11:0] i, input logic [15:0] exp, input string name);
    PCWRITE = w;
    PCSRC   = s;
    JADDR   = j;
    IMM     = i;
    PCIN    = 16'($urandom);
    @(negedge CLK);
    #1;
    chk(name, PC, exp);
  endtask

  logic [15:0] pcin_tab [5] = '{16'd0, 16'd5, 16'd10, 16'd15, 16'd20};
  logic [15:0] pout_tab [5] = '{16'd2, 16'd7, 16'd12, 16'd17, 16'd22};

  initial begin
    RST = 1; PCWRITE = 0; PCSRC = 2'b00; PCIN = 16'h0; IMM = 12'h0; JADDR = 16'h0;
    #1;
    chk("reset_pc", PC, 16'h0000);
    RST = 0;

    for (int k = 0; k < 5; k++) begin
      PCIN = pcin_tab[k];
      #100;
      chk("pcout_small", PCOUT, pout_tab[k]);
      chk("carry_small", CARRY, 1'b0);
      chk("pc_static", PC, 16'h0000);
    end
    PCIN = 16'hFFFE; #10;
    chk("pcout_fffe", PCOUT, 16'h0000);
    chk("carry_fffe", CARRY, 1'b1);
    PCIN = 16'hFFFF; #10;
    chk("pcout_ffff", PCOUT, 16'h0001);
    chk("carry_ffff", CARRY, 1'b1);
    PCIN = 16'hFFFD; #10;
    chk("carry_fffd", CARRY, 1'b0);
    PCIN = 16'h0100; IMM = 12'h004; #10;
    chk("brout_fwd", BROUT, 16'h010A);
    IMM = 12'hFFF; #10;
    chk("brout_back", BROUT, 16'h0100);
    IMM = 12'h800; #10;
    chk("brout_minneg", BROUT, 16'hF102);
    PCIN = 16'hFFF0; IMM = 12'h7FF; #10;
    chk("brout_wrap", BROUT, 16'h0FF0);

    clk_run = 1;
    check_en = 1;
    @(negedge CLK); #1;
    cyc(1, 2'b10, 16'h1234, 12'h000, 16'h1234, "jmp_1234");

    #1 RST = 1;
    #1 chk("async_reset", PC, 16'h0000);
    PCWRITE = 1; PCSRC = 2'b00;
    #1 RST = 0;
    @(negedge CLK); #1;
    chk("inc_1", PC, 16'h0002);
    cyc(1, 2'b00, 16'h0000, 12'h000, 16'h0004, "inc_2");
    cyc(1, 2'b00, 16'h0000, 12'h000, 16'h0006, "inc_3");

    cyc(1, 2'b10, 16'h0010, 12'h000, 16'h0010, "jmp_0010");
    cyc(1, 2'b10, 16'h2001, 12'h000, 16'h2000, "jmp_align");
    cyc(1, 2'b11, 16'h0000, 12'h000, 16'h2000, "hold_src");
    cyc(0, 2'b00, 16'h0000, 12'h000, 16'h2000, "hold_wr0");
    cyc(0, 2'b10, 16'h4444, 12'h000, 16'h2000, "hold_wr0_jmp");
    cyc(1, 2'b01, 16'h0000, 12'hFFE, 16'h1FFE, "br_back");
    cyc(1, 2'b01, 16'h0000, 12'h005, 16'h200A, "br_fwd");

    cyc(1, 2'b10, 16'hFFFE, 12'h000, 16'hFFFE, "jmp_fffe");
    cyc(1, 2'b00, 16'h0000, 12'h000, 16'h0000, "pc_wrap");

    cyc(1, 2'b10, 16'h0800, 12'h000, 16'h0800, "jmp_0800");
    RST = 1;
    cyc(1, 2'b00, 16'h0000, 12'h000, 16'h0000, "rst_priority");
    RST = 0;
    cyc(1, 2'b00, 16'h0000, 12'h000, 16'h0002, "post_rst_inc");

    for (int k = 0; k < 20; k++) begin
      PCWRITE = 1'($urandom);
      PCSRC   = 2'($urandom);
      JADDR   = 16'($urandom);
      IMM     = 12'($urandom);
      PCIN    = 16'($urandom);
      @(negedge CLK); #1;
    end

    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
